// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rle_pkg
// Description : Shared widths, FSM state type, symbol struct and helpers for
//               the run-length beat sequencer. Optional feature macro:
//               RLE_ZRL_EN (splits runs longer than 15 into ZRL symbols).
// Revision    : 1.0 - initial release
// ============================================================================
package rle_pkg;

  localparam int COEF_W     = 8;
  localparam int RUN_W      = 6;
  localparam int ENTRY_W    = 14;
  localparam int BEAT_COEFS = 8;
  localparam int BEATS      = 8;
  localparam int BEAT_W     = COEF_W * BEAT_COEFS;
  localparam int ARRAY_W    = ENTRY_W * BEAT_COEFS;

  // A ZRL symbol stands for 16 zeros and is coded as run=15, value=0
  localparam logic [RUN_W-1:0] ZRL_RUN  = 6'd15;
  localparam logic [RUN_W-1:0] ZRL_SPAN = 6'd16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EMIT    = 2'd2,
    ST_EOB     = 2'd3
  } state_e;

  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [COEF_W-1:0] value;
    logic              last;
  } sym_t;

  localparam sym_t EOB_SYM = '{run: '0, value: '0, last: 1'b1};
  localparam sym_t ZRL_SYM = '{run: ZRL_RUN, value: '0, last: 1'b0};

  // Pull entry idx out of the packed compressor array ({run, value} per entry)
  function automatic logic [ENTRY_W-1:0] get_entry(input logic [ARRAY_W-1:0] arr,
                                                   input logic [2:0]         idx);
    return arr[idx*ENTRY_W +: ENTRY_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rle_run_splitter.sv
`default_nettype none
// ============================================================================
// Module      : rle_run_splitter
// Description : Chops a long zero run into ZRL symbols. Given the current
//               entry's remaining run and value it returns the next symbol,
//               whether the entry is consumed, and the run left afterwards.
//               Only built when RLE_ZRL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef RLE_ZRL_EN
module rle_run_splitter
  import rle_pkg::*;
(
  input  logic [RUN_W-1:0]  run_i,
  input  logic [COEF_W-1:0] value_i,
  output logic [RUN_W-1:0]  sym_run_o,
  output logic [COEF_W-1:0] sym_value_o,
  output logic              consume_o,
  output logic [RUN_W-1:0]  rem_run_o
);

  // Runs above 15 emit one ZRL and keep the entry; otherwise emit the entry
  always_comb begin
    sym_run_o   = run_i;
    sym_value_o = value_i;
    consume_o   = 1'b1;
    rem_run_o   = run_i;
    if (run_i > ZRL_RUN) begin
      sym_run_o   = ZRL_SYM.run;
      sym_value_o = ZRL_SYM.value;
      consume_o   = 1'b0;
      rem_run_o   = run_i - ZRL_SPAN;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/rle_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rle_beat_sequencer
// Description : Walks one 64-coefficient block through the 8-coefficient RLE
//               compressor a beat at a time, carrying zero runs across beats,
//               serialising (run, value) symbols and appending EOB when the
//               block ends in zeros. Optional feature macro: RLE_ZRL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rle_beat_sequencer
  import rle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BEAT_W-1:0]  in_data,
  output logic [BEAT_W-1:0]  cmp_data,
  input  logic               cmp_flag,
  input  logic [2:0]         cmp_left,
  input  logic [2:0]         cmp_right,
  input  logic [ARRAY_W-1:0] cmp_array,
  input  logic [3:0]         cmp_size,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RUN_W-1:0]   out_run,
  output logic [COEF_W-1:0]  out_value,
  output logic               out_last,
  output logic               busy
);

  state_e               state_q;
  logic [BEAT_W-1:0]    cmp_data_q;
  logic [2:0]           beat_cnt_q;
  logic [RUN_W-1:0]     pending_q;
  logic [ARRAY_W-1:0]   arr_q;
  logic [3:0]           size_q;
  logic [2:0]           idx_q;
  logic [RUN_W-1:0]     rem_q;
  logic                 consumed_q;
  logic                 out_valid_q;
  sym_t                 sym_q;

  logic [2:0]           w_entry_idx;
  logic [ENTRY_W-1:0]   w_entry;
  logic [2:0]           w_sel_idx;
  logic [RUN_W-1:0]     w_sel_run;
  logic [COEF_W-1:0]    w_sel_val;
  logic [3:0]           w_sel_size;
  logic [RUN_W-1:0]     w_pend_after;
  logic [RUN_W-1:0]     w_split_run;
  logic [COEF_W-1:0]    w_split_val;
  logic                 w_consume;
  logic [RUN_W-1:0]     w_rem;
  logic                 w_last_beat;
  logic                 w_sym_last;
  logic                 w_beat_done;
  logic                 w_out_hs;

  // A ZRL keeps the same entry (with its reduced run); otherwise move to the next one
  assign w_entry_idx = consumed_q ? (idx_q + 3'd1) : idx_q;
  assign w_entry     = get_entry(arr_q, w_entry_idx);

  // Pick the entry whose symbol is loaded next: entry 0 straight from the
  // compressor during CAPTURE (run extended by the carried zeros), else from the latch
  always_comb begin
    w_sel_idx    = w_entry_idx;
    w_sel_run    = consumed_q ? w_entry[ENTRY_W-1:COEF_W] : rem_q;
    w_sel_val    = w_entry[COEF_W-1:0];
    w_sel_size   = size_q;
    w_pend_after = pending_q;
    if (state_q == ST_CAPTURE) begin
      w_sel_idx    = '0;
      w_sel_run    = pending_q + RUN_W'(cmp_right);
      w_sel_val    = cmp_array[COEF_W-1:0];
      w_sel_size   = cmp_size;
      w_pend_after = RUN_W'(cmp_left);
    end
  end

`ifdef RLE_ZRL_EN
  rle_run_splitter u_splitter (
    .run_i       (w_sel_run),
    .value_i     (w_sel_val),
    .sym_run_o   (w_split_run),
    .sym_value_o (w_split_val),
    .consume_o   (w_consume),
    .rem_run_o   (w_rem)
  );
`else
  assign w_split_run = w_sel_run;
  assign w_split_val = w_sel_val;
  assign w_consume   = 1'b1;
  assign w_rem       = w_sel_run;
`endif

  assign w_last_beat = (beat_cnt_q == 3'(BEATS - 1));
  // The final entry of the final beat closes the block when no zeros trail it
  assign w_sym_last  = w_consume && ({1'b0, w_sel_idx} == (w_sel_size - 4'd1)) &&
                       w_last_beat && (w_pend_after == '0);
  assign w_beat_done = consumed_q && ({1'b0, idx_q} == (size_q - 4'd1));
  assign w_out_hs    = out_valid_q && out_ready;

  // Beat sequencing FSM; all symbol outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmp_data_q  <= '0;
      beat_cnt_q  <= '0;
      pending_q   <= '0;
      arr_q       <= '0;
      size_q      <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      consumed_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sym_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cmp_data_q <= in_data;
            state_q    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!cmp_flag) begin
            pending_q <= pending_q + 6'd8;
            if (w_last_beat) begin
              out_valid_q <= 1'b1;
              sym_q       <= EOB_SYM;
              state_q     <= ST_EOB;
            end else begin
              beat_cnt_q <= beat_cnt_q + 3'd1;
              state_q    <= ST_IDLE;
            end
          end else begin
            arr_q       <= cmp_array;
            size_q      <= cmp_size;
            pending_q   <= w_pend_after;
            idx_q       <= '0;
            consumed_q  <= w_consume;
            rem_q       <= w_rem;
            out_valid_q <= 1'b1;
            sym_q       <= '{run: w_split_run, value: w_split_val, last: w_sym_last};
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_out_hs) begin
            if (w_beat_done) begin
              if (w_last_beat && (pending_q != '0)) begin
                sym_q   <= EOB_SYM;
                state_q <= ST_EOB;
              end else begin
                out_valid_q <= 1'b0;
                sym_q       <= '0;
                beat_cnt_q  <= w_last_beat ? 3'd0 : (beat_cnt_q + 3'd1);
                state_q     <= ST_IDLE;
              end
            end else begin
              idx_q      <= w_sel_idx;
              consumed_q <= w_consume;
              rem_q      <= w_rem;
              sym_q      <= '{run: w_split_run, value: w_split_val, last: w_sym_last};
            end
          end
        end
        ST_EOB: begin
          if (w_out_hs) begin
            out_valid_q <= 1'b0;
            sym_q       <= '0;
            pending_q   <= '0;
            beat_cnt_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign cmp_data  = cmp_data_q;
  assign out_valid = out_valid_q;
  assign out_run   = sym_q.run;
  assign out_value = sym_q.value;
  assign out_last  = sym_q.last;
  assign busy      = (beat_cnt_q != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rle_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rle_beat_sequencer
// Description : Self-checking bench for rle_beat_sequencer. Models the
//               combinational compressor and a block-level RLE reference.
//               Honors RLE_ZRL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_beat_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [63:0]  cmp_data;
  logic         cmp_flag;
  logic [2:0]   cmp_left;
  logic [2:0]   cmp_right;
  logic [111:0] cmp_array;
  logic [3:0]   cmp_size;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_run;
  logic [7:0]   out_value;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit rdy_rand  = 1'b0;
  bit rdy_fixed = 1'b0;
  bit gap_en    = 1'b0;

  logic [7:0]  blk [64];
  logic [14:0] got_q [$];
  logic [14:0] exp_q [$];

  typedef struct {
    int          p0;
    logic [7:0]  v0;
    int          p1;
    logic [7:0]  v1;
    int          exp_n;
    logic [14:0] exp_first;
    logic [14:0] exp_last;
  } vec_t;
  vec_t vecs [9];

  rle_beat_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cmp_data  (cmp_data),
    .cmp_flag  (cmp_flag),
    .cmp_left  (cmp_left),
    .cmp_right (cmp_right),
    .cmp_array (cmp_array),
    .cmp_size  (cmp_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_value (out_value),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compressor model: packs nonzero coefficients with the zeros before each
  function automatic void compress(input logic [63:0] d, output logic flag,
                                   output logic [2:0] left, output logic [2:0] right,
                                   output logic [111:0] arr, output logic [3:0] size);
    int n;
    int run;
    int last_nz;
    logic [7:0] b;
    flag = 1'b0; left = '0; right = '0; arr = '0; size = '0;
    n = 0; run = 0; last_nz = -1;
    for (int i = 0; i < 8; i++) begin
      b = d[i*8 +: 8];
      if (b != 8'd0) begin
        if (n == 0) right = 3'(i);
        arr[n*14 +: 14] = {(n == 0) ? 6'd0 : 6'(run), b};
        n++;
        run = 0;
        last_nz = i;
      end else begin
        run++;
      end
    end
    if (n > 0) begin
      flag = 1'b1;
      left = 3'(7 - last_nz);
      size = 4'(n);
    end
  endfunction

  always_comb compress(cmp_data, cmp_flag, cmp_left, cmp_right, cmp_array, cmp_size);

  function automatic logic [14:0] S(input int r, input int v, input bit l);
    return {6'(r), 8'(v), l};
  endfunction

  // Block-level reference: count zeros, emit symbols, finish with EOB or last flag
  task automatic build_expected();
    int run;
    logic [14:0] t;
    exp_q.delete();
    run = 0;
    for (int i = 0; i < 64; i++) begin
      if (blk[i] == 8'd0) begin
        run++;
      end else begin
`ifdef RLE_ZRL_EN
        while (run > 15) begin
          exp_q.push_back(S(15, 0, 1'b0));
          run -= 16;
        end
`endif
        exp_q.push_back(S(run, blk[i], 1'b0));
        run = 0;
      end
    end
    if (run > 0) begin
      exp_q.push_back(S(0, 0, 1'b1));
    end else begin
      t = exp_q.pop_back();
      t[0] = 1'b1;
      exp_q.push_back(t);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [14:0] got_at(input int i);
    if (i >= 0 && i < got_q.size()) return got_q[i];
    return 15'h7fff;
  endfunction

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 8'd0;
  endtask

  // Downstream ready: random or fixed, changed just after each rising edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // Symbol monitor plus hold-stability check under backpressure
  initial begin
    logic        prev_stall;
    logic [14:0] prev_sym;
    prev_stall = 1'b0;
    prev_sym   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || ({out_run, out_value, out_last} !== prev_sym)) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0d sym=%h expected valid=1 sym=%h",
                     out_valid, {out_run, out_value, out_last}, prev_sym);
          end
        end
        if (out_valid && out_ready) got_q.push_back({out_run, out_value, out_last});
        prev_stall = out_valid && !out_ready;
        prev_sym   = {out_run, out_value, out_last};
      end
    end
  end

  task automatic send_beat(input int b);
    int n;
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = blk[b*8 + i];
    if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (beat %0d)", b);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input int first, input int stop);
    for (int b = first; b < stop; b++) send_beat(b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy || out_valid) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0d valid=%0d expected 0", busy, out_valid);
    end
  endtask

  task automatic compare_model(input string name);
    int bad;
    bad = -1;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_sym[%0d]: got %h expected %h", name, bad, got_q[bad], exp_q[bad]);
    end
  endtask

  task automatic run_block(input string name);
    got_q.delete();
    build_expected();
    send_beats(0, 8);
    wait_idle();
    compare_model(name);
  endtask

  task automatic set_vec(input int k, input int p0, input int v0, input int p1, input int v1,
                         input int n, input logic [14:0] f, input logic [14:0] l);
    vecs[k].p0 = p0; vecs[k].v0 = 8'(v0);
    vecs[k].p1 = p1; vecs[k].v1 = 8'(v1);
    vecs[k].exp_n = n; vecs[k].exp_first = f; vecs[k].exp_last = l;
  endtask

  initial begin
    int n;
    int nl;
    int dens;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // {coefficient positions/values, expected symbol count, first and last symbols}
    set_vec(0,  0, 8'h05, -1, 0, 2, S(0, 8'h05, 0),  S(0, 0, 1));
    set_vec(1, 10, 8'h11, -1, 0, 2, S(10, 8'h11, 0), S(0, 0, 1));
    set_vec(2, -1, 0,     -1, 0, 1, S(0, 0, 1),      S(0, 0, 1));
`ifdef RLE_ZRL_EN
    set_vec(3, 40, 8'h7F, -1, 0, 4, S(15, 0, 0),     S(0, 0, 1));
    set_vec(4, 63, 8'h80, -1, 0, 4, S(15, 0, 0),     S(15, 8'h80, 1));
    set_vec(5,  0, 8'h01, 63, 2, 5, S(0, 1, 0),      S(14, 2, 1));
    set_vec(8, 16, 8'h22, -1, 0, 3, S(15, 0, 0),     S(0, 0, 1));
`else
    set_vec(3, 40, 8'h7F, -1, 0, 2, S(40, 8'h7F, 0), S(0, 0, 1));
    set_vec(4, 63, 8'h80, -1, 0, 1, S(63, 8'h80, 1), S(63, 8'h80, 1));
    set_vec(5,  0, 8'h01, 63, 2, 2, S(0, 1, 0),      S(62, 2, 1));
    set_vec(8, 16, 8'h22, -1, 0, 2, S(16, 8'h22, 0), S(0, 0, 1));
`endif
    set_vec(6,  7, 8'h03,  8, 4, 3, S(7, 3, 0),      S(0, 0, 1));
    set_vec(7, 15, 8'hFF, 16, 1, 3, S(15, 8'hFF, 0), S(0, 0, 1));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_run",   out_run,   0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_cmp_data",  cmp_data,  0);
    chk("rst_busy",      busy,      0);
    rst_n = 1'b1;

    // Latency plus three-cycle stall on the first symbol
    clear_blk(); blk[0] = 8'h05;
    build_expected(); got_q.delete();
    rdy_rand = 0; rdy_fixed = 0; gap_en = 0;
    @(negedge clk);
    send_beat(0);
    chk("lat_capture_valid", out_valid, 0);
    chk("lat_capture_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("lat_first_valid", out_valid, 1);
    chk("lat_first_sym", {out_run, out_value, out_last}, S(0, 5, 0));
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, out_run, out_value, out_last}, {1'b1, S(0, 5, 0)});
    end
    rdy_fixed = 1;
    send_beats(1, 8);
    wait_idle();
    compare_model("coef0_stall");

    // Table-driven sparse blocks
    rdy_fixed = 1;
    for (int t = 0; t < 9; t++) begin
      clear_blk();
      if (vecs[t].p0 >= 0) blk[vecs[t].p0] = vecs[t].v0;
      if (vecs[t].p1 >= 0) blk[vecs[t].p1] = vecs[t].v1;
      run_block($sformatf("vec%0d", t));
      chk($sformatf("vec%0d_n", t), got_q.size(), vecs[t].exp_n);
      chk($sformatf("vec%0d_first", t), got_at(0), vecs[t].exp_first);
      chk($sformatf("vec%0d_last", t), got_at(got_q.size() - 1), vecs[t].exp_last);
    end

    // All 0x01: 64 symbols, last flag only on the 64th, no EOB
    for (int i = 0; i < 64; i++) blk[i] = 8'h01;
    run_block("all_ones");
    nl = 0;
    foreach (got_q[i]) if (got_q[i][0]) nl++;
    chk("ones_last_count", nl, 1);
    chk("ones_sym63", got_at(63), S(0, 1, 1));

    // All zero with EOB held, then busy drops after the handshake
    clear_blk(); build_expected(); got_q.delete();
    rdy_fixed = 0;
    @(negedge clk);
    send_beats(0, 8);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("eob_valid", out_valid, 1);
    chk("eob_sym", {out_run, out_value, out_last}, S(0, 0, 1));
    chk("eob_busy_before", busy, 1);
    rdy_fixed = 1;
    n = 0;
    while (got_q.size() < 1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    chk("eob_busy_after", busy, 0);
    chk("eob_valid_after", out_valid, 0);
    compare_model("all_zero_hold");

    // Reset during beat 4 with a symbol stalled, then a fresh block
    clear_blk();
    for (int i = 32; i < 36; i++) blk[i] = 8'(i);
    got_q.delete();
    rdy_fixed = 0;
    @(negedge clk);
    send_beats(0, 5);
    @(posedge clk); #1;
    chk("rst_mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_blk(); blk[3] = 8'h07; blk[50] = 8'h09;
    rdy_rand = 1; gap_en = 1;
    run_block("after_reset");
    chk("after_reset_first", got_at(0), S(3, 7, 0));

    // Randomized blocks with backpressure and input gaps
    for (int r = 0; r < 30; r++) begin
      dens = $urandom_range(0, 4);
      for (int i = 0; i < 64; i++) begin
        case (dens)
          0: blk[i] = 8'd0;
          1: blk[i] = ($urandom_range(0, 40) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
          2: blk[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
          3: blk[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
          default: blk[i] = 8'($urandom_range(1, 255));
        endcase
      end
      run_block($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
